decode_writeback: RTL and testbench

//  Y86-64 pipeline decode stage plus register file write-back. Consumes the D_* pipeline

---
 rtl/y86_pkg.sv | 64 ++++++
 rtl/decode_writeback_if.sv | 13 +
 rtl/y86_regfile.sv | 32 +++
 rtl/decode_writeback.sv | 117 +++++++++++
 tb/tb_decode_writeback.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode, register-ID and stat constants plus the E pipeline register record
package y86_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 15;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] SAOK = 4'b1000;
    localparam logic [3:0] SHLT = 4'b0100;
    localparam logic [3:0] SADR = 4'b0010;
    localparam logic [3:0] SINS = 4'b0001;

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valc;
        logic [XLEN-1:0] vala;
        logic [XLEN-1:0] valb;
        logic [3:0]      dste;
        logic [3:0]      dstm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat: SAOK, icode: INOP, ifun: 4'h0,
        valc: '0, vala: '0, valb: '0,
        dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
    };

    // A source of RNONE never matches a destination and reads as zero.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [3:0] src, input logic [XLEN-1:0] rf_val,
        input logic [3:0] e_dst, input logic [XLEN-1:0] e_val,
        input logic [3:0] mm_dst, input logic [XLEN-1:0] mm_val,
        input logic [3:0] me_dst, input logic [XLEN-1:0] me_val,
        input logic [3:0] wm_dst, input logic [XLEN-1:0] wm_val,
        input logic [3:0] we_dst, input logic [XLEN-1:0] we_val);
        if (src == RNONE)       return '0;
        else if (src == e_dst)  return e_val;
        else if (src == mm_dst) return mm_val;
        else if (src == me_dst) return me_val;
        else if (src == wm_dst) return wm_val;
        else if (src == we_dst) return we_val;
        else                    return rf_val;
    endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// rtl/decode_writeback_if.sv - D pipeline register bundle from fetch into decode
interface decode_writeback_if;
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    modport master (output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP);
    modport slave  (input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP);
endinterface

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15x64 register file, 2 async read ports, 2 sync write ports, async clear
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      src_a,
    input  logic [3:0]      src_b,
    output logic [XLEN-1:0] val_a,
    output logic [XLEN-1:0] val_b,
    input  logic [3:0]      dst_e,
    input  logic [XLEN-1:0] wdata_e,
    input  logic [3:0]      dst_m,
    input  logic [XLEN-1:0] wdata_m
);

    logic [XLEN-1:0] regs [NREGS];

    // Port M is written last so it wins when both ports target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (dst_e != RNONE) regs[dst_e] <= wdata_e;
            if (dst_m != RNONE) regs[dst_m] <= wdata_m;
        end
    end

    assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
    assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode stage with register write-back; DECODE_FORWARD_EN enables operand forwarding
module decode_writeback
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    decode_writeback_if.slave  d,
    input  logic               E_bubble,
    input  logic [3:0]         e_dstE,
    input  logic [XLEN-1:0]    e_valE,
    input  logic [3:0]         M_dstE,
    input  logic [XLEN-1:0]    M_valE,
    input  logic [3:0]         M_dstM,
    input  logic [XLEN-1:0]    m_valM,
    input  logic [3:0]         W_dstE,
    input  logic [XLEN-1:0]    W_valE,
    input  logic [3:0]         W_dstM,
    input  logic [XLEN-1:0]    W_valM,
    output logic [3:0]         d_srcA,
    output logic [3:0]         d_srcB,
    output logic [3:0]         E_stat,
    output logic [3:0]         E_icode,
    output logic [3:0]         E_ifun,
    output logic [XLEN-1:0]    E_valC,
    output logic [XLEN-1:0]    E_valA,
    output logic [XLEN-1:0]    E_valB,
    output logic [3:0]         E_dstE,
    output logic [3:0]         E_dstM,
    output logic [3:0]         E_srcA,
    output logic [3:0]         E_srcB
);

    logic [3:0]      src_a, src_b, dst_e, dst_m;
    logic [XLEN-1:0] rf_a, rf_b, sel_a, sel_b, d_vala;
    e_reg_t          e_d, e_q;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d.D_icode)
            IRRMOVQ: begin src_a = d.D_rA; dst_e = d.D_rB; end
            IIRMOVQ: dst_e = d.D_rB;
            IRMMOVQ: begin src_a = d.D_rA; src_b = d.D_rB; end
            IMRMOVQ: begin src_b = d.D_rB; dst_m = d.D_rA; end
            IOPQ:    begin src_a = d.D_rA; src_b = d.D_rB; dst_e = d.D_rB; end
            ICALL:   begin src_b = RRSP; dst_e = RRSP; end
            IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
            IPUSHQ:  begin src_a = d.D_rA; src_b = RRSP; dst_e = RRSP; end
            IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = d.D_rA; end
            default: ;
        endcase
    end

    y86_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .src_a   (src_a),
        .src_b   (src_b),
        .val_a   (rf_a),
        .val_b   (rf_b),
        .dst_e   (W_dstE),
        .wdata_e (W_valE),
        .dst_m   (W_dstM),
        .wdata_m (W_valM)
    );

`ifdef DECODE_FORWARD_EN
    assign sel_a = fwd_select(src_a, rf_a, e_dstE, e_valE, M_dstM, m_valM,
                              M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    assign sel_b = fwd_select(src_b, rf_b, e_dstE, e_valE, M_dstM, m_valM,
                              M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
`else
    // Hazard control stalls every RAW dependency, so the later-stage buses go unread.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
    assign sel_a = rf_a;
    assign sel_b = rf_b;
`endif

    assign d_vala = (d.D_icode == ICALL || d.D_icode == IJXX) ? d.D_valP : sel_a;

    always_comb begin
        e_d       = E_BUBBLE;
        e_d.stat  = d.D_stat;
        e_d.icode = d.D_icode;
        e_d.ifun  = d.D_ifun;
        e_d.valc  = d.D_valC;
        e_d.vala  = d_vala;
        e_d.valb  = sel_b;
        e_d.dste  = dst_e;
        e_d.dstm  = dst_m;
        e_d.srca  = src_a;
        e_d.srcb  = src_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        e_q <= E_BUBBLE;
        else if (E_bubble) e_q <= E_BUBBLE;
        else               e_q <= e_d;
    end

    assign d_srcA  = src_a;
    assign d_srcB  = src_b;
    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - randomized self-checking bench for decode_writeback against a rule-table model
module tb_decode_writeback;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_writeback_if dif();

    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .d(dif), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] rf [15];

    // Field selector per icode: 0 none, 1 rA, 2 rB, 3 %rsp
    int sel_srca [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
    int sel_srcb [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
    int sel_dste [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
    int sel_dstm [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pick(input int sel, input logic [3:0] ra, input logic [3:0] rb);
        case (sel)
            1:       return ra;
            2:       return rb;
            3:       return 4'h4;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [3:0] src);
        logic [3:0]  fd [5];
        logic [63:0] fv [5];
        if (src == 4'hF) return 64'd0;
        fd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        fv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
`ifdef DECODE_FORWARD_EN
        for (int i = 0; i < 5; i++) if (fd[i] == src) return fv[i];
`endif
        return rf[src];
    endfunction

    task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        dif.D_stat = 4'b1000; dif.D_icode = ic; dif.D_ifun = fn;
        dif.D_rA = ra; dif.D_rB = rb; dif.D_valC = vc; dif.D_valP = vp;
    endtask

    task automatic idle();
        set_d(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        E_bubble = 1'b0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 3) != 0) return 4'($urandom_range(0, 3));
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] rand_dst();
        if ($urandom_range(0, 2) == 0) return 4'hF;
        return 4'($urandom_range(0, 4));
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_inputs();
        logic [3:0] st;
        st = 4'b1000 >> $urandom_range(0, 3);
        set_d(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rand_reg(), rand_reg(),
              rand64(), rand64());
        dif.D_stat = st;
        E_bubble = ($urandom_range(0, 7) == 0);
        e_dstE = rand_dst(); M_dstE = rand_dst(); M_dstM = rand_dst();
        W_dstE = rand_dst(); W_dstM = rand_dst();
        e_valE = rand64(); M_valE = rand64(); m_valM = rand64(); W_valE = rand64(); W_valM = rand64();
    endtask

    // Applies current inputs across one clock edge and compares the E register with the model.
    task automatic step();
        logic [3:0]  sa, sb, de, dm, ic, st, fn;
        logic [63:0] va, vb, vc;
        logic        bub;
        #1;
        ic = dif.D_icode;
        sa = pick(sel_srca[ic], dif.D_rA, dif.D_rB);
        sb = pick(sel_srcb[ic], dif.D_rA, dif.D_rB);
        de = pick(sel_dste[ic], dif.D_rA, dif.D_rB);
        dm = pick(sel_dstm[ic], dif.D_rA, dif.D_rB);
        va = (ic == 4'h7 || ic == 4'h8) ? dif.D_valP : model_read(sa);
        vb = model_read(sb);
        st = dif.D_stat; fn = dif.D_ifun; vc = dif.D_valC;
        bub = E_bubble;
        check("d_srcA", 64'(d_srcA), 64'(sa));
        check("d_srcB", 64'(d_srcB), 64'(sb));
        if (bub) begin
            st = 4'b1000; ic = 4'h1; fn = 4'h0; vc = '0; va = '0; vb = '0;
            sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
        end
        @(posedge clk);
        #1;
        if (W_dstE != 4'hF) rf[W_dstE] = W_valE;
        if (W_dstM != 4'hF) rf[W_dstM] = W_valM;
        check("E_stat", 64'(E_stat), 64'(st));
        check("E_icode", 64'(E_icode), 64'(ic));
        check("E_ifun", 64'(E_ifun), 64'(fn));
        check("E_valC", E_valC, vc);
        check("E_valA", E_valA, va);
        check("E_valB", E_valB, vb);
        check("E_dstE", 64'(E_dstE), 64'(de));
        check("E_dstM", 64'(E_dstM), 64'(dm));
        check("E_srcA", 64'(E_srcA), 64'(sa));
        check("E_srcB", 64'(E_srcB), 64'(sb));
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 15; i++) begin
            idle();
            set_d(4'h2, 4'h0, 4'(i), 4'h0, 64'd0, 64'd0);
            step();
            check(tag, E_valA, 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 15; i++) rf[i] = '0;
        #12;
        check("rst_icode", 64'(E_icode), 64'h1);
        check("rst_stat", 64'(E_stat), 64'h8);
        check("rst_dstE", 64'(E_dstE), 64'hF);
        rst_n = 1'b1;
        check_regs_zero("rst_reg");

        // irmovq $5,%rbx; write-back; addq %rbx,%rcx
        idle(); set_d(4'h3, 4'h0, 4'hF, 4'h3, 64'd5, 64'd10);
        step();
        check("irmov_dstE", 64'(E_dstE), 64'h3);
        idle(); W_dstE = 4'h3; W_valE = 64'd5;
        step();
        idle(); set_d(4'h6, 4'h0, 4'h3, 4'h1, 64'd0, 64'd12);
        step();
        check("addq_valA", E_valA, 64'd5);

        // forwarding priority: execute beats write-back
        idle(); W_dstE = 4'h2; W_valE = 64'h22;
        step();
        idle(); set_d(4'h2, 4'h0, 4'h2, 4'h7, 64'd0, 64'd0);
        e_dstE = 4'h2; e_valE = 64'd7; W_dstE = 4'h2; W_valE = 64'd9;
        step();
`ifdef DECODE_FORWARD_EN
        check("fwd_prio", E_valA, 64'd7);
`else
        check("nofwd_rf", E_valA, 64'h22);
`endif

        // call 0x100
        idle(); set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);
        step();
        check("call_valA", E_valA, 64'h40);
        check("call_srcB", 64'(E_srcB), 64'h4);
        check("call_dstE", 64'(E_dstE), 64'h4);
        check("call_valC", E_valC, 64'h100);

        // dual write to same register: M port wins; then a bubble
        idle(); W_dstE = 4'h6; W_valE = 64'd1; W_dstM = 4'h6; W_valM = 64'd2;
        step();
        idle(); set_d(4'h2, 4'h0, 4'h6, 4'h0, 64'd0, 64'd0);
        step();
        check("dual_wr", E_valA, 64'd2);
        idle(); set_d(4'h6, 4'h1, 4'h6, 4'h6, 64'h55, 64'd0); E_bubble = 1'b1;
        step();
        check("bub_icode", 64'(E_icode), 64'h1);
        check("bub_valA", E_valA, 64'd0);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end

        // asynchronous reset mid-instruction with a pending write-back
        rand_inputs();
        E_bubble = 1'b0; W_dstE = 4'h3; W_valE = 64'hDEAD; W_dstM = 4'h5; W_valM = 64'hBEEF;
        #2 rst_n = 1'b0;
        #1;
        check("arst_icode", 64'(E_icode), 64'h1);
        check("arst_stat", 64'(E_stat), 64'h8);
        check("arst_dstE", 64'(E_dstE), 64'hF);
        @(posedge clk);
        #1;
        check("arst_hold", 64'(E_icode), 64'h1);
        idle();
        for (int i = 0; i < 15; i++) rf[i] = '0;
        #2 rst_n = 1'b1;
        check_regs_zero("arst_reg");

        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
